conv2d_3x3_channel_sequencer: RTL and testbench

Controller that time-shares one 3x3 stride-1 padding-1 convolution datapath across NUM_CH filter passes over a frame. For each pass it loads nine 32-bit weights into the kernel registers, streams IMG_WIDHT*IMG_HEIGHT pixels into the datapath, and waits until the same number of results have returned. It tags every returned result with its pass index and pulses done after the last pass. It sits between the weight/pixel memories and the convolution datapath.

---
 rtl/conv2d_3x3_channel_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_conv2d_3x3_channel_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_3x3_channel_sequencer.sv
// conv2d_3x3_channel_sequencer
// Runs one shared 3x3 convolution datapath once per filter pass. Each pass
// loads nine kernel weights, streams one frame of pixels into the datapath
// and waits for the same number of results to return. Every result is tagged
// with its pass index, and done pulses once after the last pass.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   start               job request, only looked at in IDLE
//   busy, done          job in progress / one-cycle end-of-job pulse
//   W_Data_In/W_Valid_In/W_Ready         weight stream (valid/ready)
//   Pix_Data_In/Pix_Valid_In/Pix_Ready   pixel stream, raster order
//   Conv_Data_Out/Conv_Valid_Out         registered pixel to the datapath
//   Kernel_Flat         nine weights, Kernel0 in the least significant word
//   Conv_Data_In/Conv_Valid_In           result from the datapath
//   Res_Data_Out/Res_Valid_Out/Res_Ch_Out registered result and its pass
//   Ch_Idx              current pass index
//   Err_Out             sticky protocol error, cleared by the next start
module conv2d_3x3_channel_sequencer #(
    parameter int  IMG_WIDHT  = 30,
    parameter int  IMG_HEIGHT = 30,
    parameter int  NUM_CH     = 4,
    parameter int  DATA_WIDHT = 32,
    localparam int NPIX       = IMG_WIDHT * IMG_HEIGHT,
    localparam int CNT_W      = $clog2(NPIX + 1),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [DATA_WIDHT-1:0]   W_Data_In,
    input  logic                    W_Valid_In,
    output logic                    W_Ready,
    input  logic [DATA_WIDHT-1:0]   Pix_Data_In,
    input  logic                    Pix_Valid_In,
    output logic                    Pix_Ready,
    output logic [DATA_WIDHT-1:0]   Conv_Data_Out,
    output logic                    Conv_Valid_Out,
    output logic [9*DATA_WIDHT-1:0] Kernel_Flat,
    input  logic [DATA_WIDHT-1:0]   Conv_Data_In,
    input  logic                    Conv_Valid_In,
    output logic [DATA_WIDHT-1:0]   Res_Data_Out,
    output logic                    Res_Valid_Out,
    output logic [CH_W-1:0]         Res_Ch_Out,
    output logic [CH_W-1:0]         Ch_Idx,
    output logic                    Err_Out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             wcnt_q;
    logic [CNT_W-1:0]       pcnt_q;
    logic [CNT_W-1:0]       ocnt_q;
    logic [CH_W-1:0]        ch_q;
    logic [DATA_WIDHT-1:0]  conv_data_q;
    logic                   conv_valid_q;
    logic [DATA_WIDHT-1:0]  res_data_q;
    logic                   res_valid_q;
    logic [CH_W-1:0]        res_ch_q;
    logic                   err_q;

    logic job_start, w_fire, p_fire, in_pass, ocnt_full, res_count;
    logic last_w, last_pix, last_ch, drain_done, pass_next, err_hit;

    assign job_start = (state_q == S_IDLE) && start;
    assign w_fire    = (state_q == S_LOAD_W) && W_Valid_In;
    assign p_fire    = (state_q == S_STREAM) && Pix_Valid_In;
    assign in_pass   = (state_q == S_LOAD_W) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign ocnt_full = (ocnt_q == CNT_W'(NPIX));
    // A result beyond the frame size is forwarded but never counted.
    assign res_count = Conv_Valid_In && in_pass && !ocnt_full;
    assign last_w    = (wcnt_q == 4'd8);
    assign last_pix  = (pcnt_q == CNT_W'(NPIX - 1));
    assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));
    // The pass ends as soon as the final result is seen, including a result
    // arriving in this very cycle.
    assign drain_done = (state_q == S_DRAIN) &&
                        (ocnt_full || (res_count && (ocnt_q == CNT_W'(NPIX - 1))));
    assign pass_next  = drain_done && !last_ch;
    assign err_hit    = Conv_Valid_In &&
                        ((state_q == S_IDLE) || (state_q == S_DONE) ||
                         ((state_q == S_LOAD_W) && (ch_q == '0)) || ocnt_full);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD_W;
            S_LOAD_W: if (w_fire && last_w) state_d = S_STREAM;
            S_STREAM: if (p_fire && last_pix) state_d = S_DRAIN;
            S_DRAIN:  if (drain_done) state_d = last_ch ? S_DONE : S_LOAD_W;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            pcnt_q       <= '0;
            ocnt_q       <= '0;
            ch_q         <= '0;
            conv_data_q  <= '0;
            conv_valid_q <= 1'b0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (job_start) begin
                wcnt_q <= '0;
                pcnt_q <= '0;
                ocnt_q <= '0;
                ch_q   <= '0;
            end

            if (w_fire) begin
                wcnt_q <= last_w ? 4'd0 : wcnt_q + 4'd1;
            end

            if (p_fire) begin
                pcnt_q <= pcnt_q + CNT_W'(1);
            end

            if (pass_next) begin
                ch_q   <= ch_q + CH_W'(1);
                pcnt_q <= '0;
                ocnt_q <= '0;
            end else if (res_count) begin
                ocnt_q <= ocnt_q + CNT_W'(1);
            end

            // One-cycle pixel register in front of the datapath; data holds
            // when nothing is accepted.
            conv_valid_q <= p_fire;
            if (p_fire) begin
                conv_data_q <= Pix_Data_In;
            end

            res_valid_q <= Conv_Valid_In;
            res_data_q  <= Conv_Data_In;
            res_ch_q    <= ch_q;

            // A violation in the same cycle as start wins over the clear.
            if (err_hit) begin
                err_q <= 1'b1;
            end else if (job_start) begin
                err_q <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_kernel
            logic [DATA_WIDHT-1:0] kernel_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    kernel_q <= '0;
                end else if (w_fire && (wcnt_q == 4'(gi))) begin
                    kernel_q <= W_Data_In;
                end
            end
            assign Kernel_Flat[gi*DATA_WIDHT +: DATA_WIDHT] = kernel_q;
        end
    endgenerate

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign W_Ready        = (state_q == S_LOAD_W);
    assign Pix_Ready      = (state_q == S_STREAM);
    assign Conv_Data_Out  = conv_data_q;
    assign Conv_Valid_Out = conv_valid_q;
    assign Res_Data_Out   = res_data_q;
    assign Res_Valid_Out  = res_valid_q;
    assign Res_Ch_Out     = res_ch_q;
    assign Ch_Idx         = ch_q;
    assign Err_Out        = err_q;

endmodule

// File: tb/tb_conv2d_3x3_channel_sequencer.sv
// Bench for conv2d_3x3_channel_sequencer on a 4x4 frame with four passes.
// A small datapath model returns f(pixel) = pixel*3+1 three cycles after each
// Conv_Valid_Out; the driver pushes expected pixels and results into queues
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_conv2d_3x3_channel_sequencer;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NCH  = 4;
    localparam int DW   = 32;
    localparam int CHW  = 2;
    localparam int NPIX = W * H;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            busy, done;
    logic [DW-1:0]   W_Data_In = '0;
    logic            W_Valid_In = 1'b0;
    logic            W_Ready;
    logic [DW-1:0]   Pix_Data_In = '0;
    logic            Pix_Valid_In = 1'b0;
    logic            Pix_Ready;
    logic [DW-1:0]   Conv_Data_Out;
    logic            Conv_Valid_Out;
    logic [9*DW-1:0] Kernel_Flat;
    logic [DW-1:0]   Conv_Data_In;
    logic            Conv_Valid_In;
    logic [DW-1:0]   Res_Data_Out;
    logic            Res_Valid_Out;
    logic [CHW-1:0]  Res_Ch_Out;
    logic [CHW-1:0]  Ch_Idx;
    logic            Err_Out;

    conv2d_3x3_channel_sequencer #(
        .IMG_WIDHT (W),
        .IMG_HEIGHT(H),
        .NUM_CH    (NCH),
        .DATA_WIDHT(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .W_Data_In     (W_Data_In),
        .W_Valid_In    (W_Valid_In),
        .W_Ready       (W_Ready),
        .Pix_Data_In   (Pix_Data_In),
        .Pix_Valid_In  (Pix_Valid_In),
        .Pix_Ready     (Pix_Ready),
        .Conv_Data_Out (Conv_Data_Out),
        .Conv_Valid_Out(Conv_Valid_Out),
        .Kernel_Flat   (Kernel_Flat),
        .Conv_Data_In  (Conv_Data_In),
        .Conv_Valid_In (Conv_Valid_In),
        .Res_Data_Out  (Res_Data_Out),
        .Res_Valid_Out (Res_Valid_Out),
        .Res_Ch_Out    (Res_Ch_Out),
        .Ch_Idx        (Ch_Idx),
        .Err_Out       (Err_Out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: latency 3; when dp_en is low the bench drives results.
    bit            dp_en = 1'b1;
    logic          inj_v = 1'b0;
    logic [DW-1:0] inj_d = '0;
    logic [2:0]    pv;
    logic [DW-1:0] pd0, pd1, pd2;

    always @(posedge clk) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv  <= {pv[1:0], Conv_Valid_Out};
            pd0 <= Conv_Data_Out * 32'd3 + 32'd1;
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end

    assign Conv_Valid_In = dp_en ? pv[2] : inj_v;
    assign Conv_Data_In  = dp_en ? pd2 : inj_d;

    function automatic logic [31:0] f(input logic [31:0] x);
        return x * 32'd3 + 32'd1;
    endfunction

    typedef struct { logic [31:0] d; int c; }  pix_exp_t;
    typedef struct { logic [31:0] d; int ch; } res_exp_t;
    pix_exp_t pix_q[$];
    res_exp_t res_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: scoreboard pops, done counting, kernel-write legality.
    pix_exp_t        pe;
    res_exp_t        re;
    logic [9*DW-1:0] prev_k;
    logic            prev_wr  = 1'b0;
    logic            prev_rst = 1'b0;

    always @(negedge clk) begin
        if (Conv_Valid_Out) begin
            if (pix_q.size() == 0) begin
                check("conv_unexpected", 1, 0);
            end else begin
                pe = pix_q.pop_front();
                check("conv_data", Conv_Data_Out, pe.d);
                check("conv_latency", cyc, pe.c);
            end
        end
        if (Res_Valid_Out) begin
            if (res_q.size() == 0) begin
                check("res_unexpected", 1, 0);
            end else begin
                re = res_q.pop_front();
                check("res_data", Res_Data_Out, re.d);
                check("res_ch", Res_Ch_Out, re.ch);
            end
        end
        if (done) done_cnt <= done_cnt + 1;
        if (prev_rst && (Kernel_Flat != prev_k)) check("kernel_only_in_load", prev_wr, 1);
        prev_k   <= Kernel_Flat;
        prev_wr  <= W_Ready;
        prev_rst <= rst;
    end

    task automatic send_w(input logic [31:0] d, input bit gap);
        bit got = 1'b0;
        W_Data_In  = d;
        W_Valid_In = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (W_Ready) got = 1'b1;
            @(posedge clk); #1;
        end
        W_Valid_In = 1'b0;
        if (!got) check("w_timeout", 0, 1);
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pix(input logic [31:0] d, input int ch, input bit gap);
        bit got = 1'b0;
        pix_exp_t p;
        res_exp_t r;
        Pix_Data_In  = d;
        Pix_Valid_In = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (Pix_Ready) begin
                got = 1'b1;
                p.d = d;
                p.c = cyc + 1;
                pix_q.push_back(p);
                if (dp_en) begin
                    r.d  = f(d);
                    r.ch = ch;
                    res_q.push_back(r);
                end
            end
            @(posedge clk); #1;
        end
        Pix_Valid_In = 1'b0;
        if (!got) check("pix_timeout", 0, 1);
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic inject(input logic [31:0] d, input int ch);
        res_exp_t r;
        r.d   = d;
        r.ch  = ch;
        res_q.push_back(r);
        inj_d = d;
        inj_v = 1'b1;
        @(posedge clk); #1;
        inj_v = 1'b0;
    endtask

    task automatic check_kernel(input string name, input int k);
        for (int i = 0; i < 9; i++) check(name, Kernel_Flat[i*DW +: DW], k * 10 + i + 1);
    endtask

    task automatic load_pass(input int k, input bit gap);
        for (int i = 0; i < 9; i++) send_w(k * 10 + i + 1, gap);
        check_kernel("kernel_load", k);
        check("ch_idx", Ch_Idx, k);
    endtask

    task automatic run_job(input logic [31:0] base, input bit gap, input bit start_mid, input bit errmode);
        int d0 = done_cnt;
        if (errmode) dp_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", Err_Out, 0);
        for (int k = 0; k < NCH; k++) begin
            load_pass(k, gap);
            if (errmode && k == 1) dp_en = 1'b1;
            for (int j = 0; j < NPIX; j++) begin
                if (errmode && k == 0 && j == NPIX - 1) begin
                    // Sixteen early results fill the pass count; the next is extra.
                    for (int i = 0; i < NPIX; i++) inject(32'hE000_0000 + i, 0);
                    check("err_before_extra", Err_Out, 0);
                    inject(32'hE000_00FF, 0);
                    check("err_extra_result", Err_Out, 1);
                end
                if (start_mid && k == 1 && j == 6) start = 1'b1;
                send_pix(base + k * 100 + j * 7, k, gap);
                start = 1'b0;
            end
            check_kernel("kernel_hold", k);
        end
        for (int t = 0; t < 200 && done_cnt == d0; t++) @(negedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("res_all_seen", res_q.size(), 0);
        check("pix_all_seen", pix_q.size(), 0);
        check("busy_after_done", busy, 0);
        check("err_at_end", Err_Out, errmode ? 1 : 0);
        $display("job base=%0h gap=%0d start_mid=%0d errmode=%0d finished at cycle %0d",
                 base, gap, start_mid, errmode, cyc);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_w_ready", W_Ready, 0);
        check("rst_pix_ready", Pix_Ready, 0);
        check("rst_conv_valid", Conv_Valid_Out, 0);
        check("rst_conv_data", Conv_Data_Out, 0);
        check("rst_res_valid", Res_Valid_Out, 0);
        check("rst_kernel_zero", |Kernel_Flat, 0);
        check("rst_ch_idx", Ch_Idx, 0);
        check("rst_err", Err_Out, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_job(32'h100, 1'b0, 1'b0, 1'b0);
        run_job(32'h200, 1'b1, 1'b1, 1'b0);

        // Result in IDLE: forwarded with the last pass index, sets sticky error.
        dp_en = 1'b0;
        inject(32'hDEAD_0001, NCH - 1);
        check("err_idle_result", Err_Out, 1);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", Err_Out, 1);

        run_job(32'h300, 1'b0, 1'b0, 1'b1);

        // Reset after the 7th pixel of pass 0 abandons the job.
        dp_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_pass(0, 1'b0);
        for (int j = 0; j < 7; j++) send_pix(32'h500 + j, 0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        res_q.delete();
        check("midrst_busy", busy, 0);
        check("midrst_kernel_zero", |Kernel_Flat, 0);
        check("midrst_conv_valid", Conv_Valid_Out, 0);
        check("midrst_res_valid", Res_Valid_Out, 0);
        check("midrst_ch_idx", Ch_Idx, 0);
        check("midrst_err", Err_Out, 0);
        check("midrst_pix_queue", pix_q.size(), 0);
        d0 = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        $display("reset mid-stream completed at cycle %0d", cyc);

        run_job(32'h400, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
